right_shift_unit: RTL and testbench

RIGHT_SHIFT_UNIT -- requirements
Module: right_shift_unit

---
 rtl/right_shift_unit_pkg.sv | 6 +
 rtl/right_shift_stage.sv | 15 +
 rtl/right_shift_unit.sv | 73 +++++++
 tb/tb_right_shift_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/right_shift_unit_pkg.sv
// right_shift_unit_pkg: shared FSM encoding and default sizes for the shifter blocks
package right_shift_unit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/right_shift_stage.sv
// right_shift_stage: one barrel stage, shifting right by 2^(SHW-1-stage) when enabled
module right_shift_stage #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   stage,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);
  logic [SHW-1:0] amt;
  assign amt = en ? SHW'(1) << (SHW'(SHW - 1) - stage) : '0;
  assign out = (data >> amt) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> amt));
endmodule

// File: rtl/right_shift_unit.sv
// right_shift_unit: multi-cycle right shifter, one barrel stage per clock, fixed SHW-cycle latency
module right_shift_unit
  import right_shift_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  state_t state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d, shamt_q, shamt_d, sel;
  logic [WIDTH-1:0] data_q, data_d, stage_out;
  logic fill_q, fill_d, last;
  // stage k consumes shamt bit SHW-1-k, largest shift first
  assign sel = shamt_q >> (SHW'(SHW - 1) - cnt_q);
  assign last = cnt_q == SHW'(SHW - 1);
  right_shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
    .data(data_q),
    .stage(cnt_q),
    .en(sel[0]),
    .fill(fill_q),
    .out(stage_out)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    shamt_d = shamt_q;
    fill_d = fill_q;
    if (state_q == IDLE && in_valid) begin
      state_d = SHIFT;
      cnt_d = '0;
      data_d = in_data;
      shamt_d = in_shamt;
      fill_d = in_arith & in_data[WIDTH-1];
    end else if (state_q == SHIFT) begin
      data_d = stage_out;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      state_d = last ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      shamt_q <= '0;
      fill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      shamt_q <= shamt_d;
      fill_q <= fill_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_data = data_q;
endmodule

// File: tb/tb_right_shift_unit.sv
// tb_right_shift_unit: randomized and directed checks of right_shift_unit against an arithmetic reference
module tb_right_shift_unit;
  localparam int W = 32;
  localparam int S = 5;
  logic clock = 1'b0;
  logic reset, in_valid, in_arith, out_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_data;
  int vectors = 0;
  int miscompares = 0;

  right_shift_unit #(.WIDTH(W), .SHW(S)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh, input bit ar);
    logic signed [W-1:0] s;
    s = d;
    if (ar) return s >>> sh;
    return d >> sh;
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_req(input logic [W-1:0] d, input logic [S-1:0] sh, input bit ar,
                         input int hold, input string tag);
    int cyc;
    logic [W-1:0] exp;
    exp = ref_shift(d, int'(sh), ar);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready before request: got %b want 1", tag, in_ready);
    end
    in_data = d; in_shamt = sh; in_arith = ar; in_valid = 1'b1;
    step();
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom; in_shamt = S'($urandom); in_arith = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy/in_ready in flight: got %b/%b want 1/0", tag, busy, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (cyc !== S) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc, S);
    end
    vectors++;
    if (out_data !== exp) begin
      miscompares++;
      $display("FAIL %s result d=%h sh=%0d ar=%0d: got %h want %h", tag, d, sh, ar, out_data, exp);
    end
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold: got v=%b d=%h r=%b want v=1 d=%h r=0", tag, out_valid, out_data, in_ready, exp);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: got v=%b r=%b b=%b want v=0 r=1 b=0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 32'hDEADBEEF; in_shamt = 5'd3; in_arith = 1'b1;
    step();
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset state: got r=%b v=%b b=%b d=%h want r=1 v=0 b=0 d=0", in_ready, out_valid, busy, out_data);
    end
    in_valid = 1'b0; reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_req(32'h80000000, 5'd4, 1'b1, 0, "arith_sh4");
    run_req(32'h80000000, 5'd4, 1'b0, 0, "logic_sh4");
    run_req(32'h80000000, 5'd31, 1'b1, 0, "arith_sh31");
    run_req(32'h80000000, 5'd31, 1'b0, 0, "logic_sh31");
    run_req(32'h12345678, 5'd0, 1'b1, 0, "sh0");
    run_req(32'h7FFFFFFF, 5'd31, 1'b1, 0, "pos_arith_sh31");
  endtask

  task automatic test_hold();
    run_req(32'hF00DCAFE, 5'd13, 1'b1, 10, "hold10");
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    in_data = 32'h80000000; in_shamt = 5'd31; in_arith = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1; in_valid = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL mid_reset state: got b=%b r=%b v=%b d=%h want b=0 r=1 v=0 d=0", busy, in_ready, out_valid, out_data);
    end
    seen = 1'b0;
    repeat (8) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset stray out_valid: got 1 want 0");
    end
    run_req(32'hCAFEBABE, 5'd7, 1'b1, 2, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++)
      run_req($urandom, S'($urandom_range(0, W - 1)), 1'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_arith = 1'b0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
